sram_axi_slave: RTL and testbench

// - AXI4 slave front end for one SRAM bank (IM or DM); sits downstream of the AXI bus and the CPU master ports.
// - Accepts INCR read/write bursts and drives the synchronous SRAM macro (CS/OE/WEB/A/DI/DO).
// - Serves one transaction at a time; returns RID/BID echoed from the request.

---
 rtl/sram_axi_slave_pkg.sv | 16 +
 rtl/sram_axi_slave_burst_counter.sv | 44 ++++
 rtl/sram_axi_slave.sv | 158 +++++++++++++++
 tb/tb_sram_axi_slave.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_axi_slave_pkg.sv
// Shared types and default widths for the SRAM AXI4 slave.
// Ports: none (package only).
// Provides the FSM state, burst and response encodings used by the slave.
package sram_axi_slave_pkg;

  localparam int DEF_ID_W   = 8;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_LEN_W  = 4;
  localparam int DEF_MEM_AW = 14;

  typedef enum logic [1:0] {IDLE, R_DATA, W_DATA, W_RESP} state_e;
  typedef enum logic [1:0] {FIXED, INCR, WRAP} burst_e;
  typedef enum logic [1:0] {OKAY, EXOKAY, SLVERR, DECERR} resp_e;

endpackage

// File: rtl/sram_axi_slave_burst_counter.sv
// Burst address/beat tracker shared by the read and write paths.
// Ports: load (latch base+len, clear count), inc (advance one beat),
//        addr/next_addr (current and following SRAM word), last (count == len).
module sram_axi_slave_burst_counter #(
  parameter int AW    = 14,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             inc,
  input  logic [AW-1:0]    base,
  input  logic [LEN_W-1:0] len,
  output logic [AW-1:0]    addr,
  output logic [AW-1:0]    next_addr,
  output logic             last
);

  localparam logic [AW-1:0]    ONE_A = AW'(1);
  localparam logic [LEN_W-1:0] ONE_L = LEN_W'(1);

  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] len_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr  <= '0;
      cnt   <= '0;
      len_q <= '0;
    end else if (load) begin
      addr  <= base;
      cnt   <= '0;
      len_q <= len;
    end else if (inc) begin
      // natural overflow gives the modulo-2^AW word wrap
      addr <= addr + ONE_A;
      cnt  <= cnt + ONE_L;
    end
  end

  assign next_addr = addr + ONE_A;
  assign last      = (cnt == len_q);

endmodule

// File: rtl/sram_axi_slave.sv
// AXI4 slave front end for one synchronous SRAM bank, one transaction at a time.
// Ports: AXI AR/R/AW/W/B channels (*_S), SRAM pins CS/OE/WEB/A/DI/DO.
// Read data follows the address by one cycle; W beats stall until the AW is taken.
module sram_axi_slave
  import sram_axi_slave_pkg::*;
#(
  parameter int ID_W   = DEF_ID_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int MEM_AW = DEF_MEM_AW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ID_W-1:0]     ARID_S,
  input  logic [ADDR_W-1:0]   ARADDR_S,
  input  logic [LEN_W-1:0]    ARLEN_S,
  input  logic [2:0]          ARSIZE_S,
  input  logic [1:0]          ARBURST_S,
  input  logic                ARVALID_S,
  output logic                ARREADY_S,
  output logic [ID_W-1:0]     RID_S,
  output logic [DATA_W-1:0]   RDATA_S,
  output logic [1:0]          RRESP_S,
  output logic                RLAST_S,
  output logic                RVALID_S,
  input  logic                RREADY_S,
  input  logic [ID_W-1:0]     AWID_S,
  input  logic [ADDR_W-1:0]   AWADDR_S,
  input  logic [LEN_W-1:0]    AWLEN_S,
  input  logic [2:0]          AWSIZE_S,
  input  logic [1:0]          AWBURST_S,
  input  logic                AWVALID_S,
  output logic                AWREADY_S,
  input  logic [DATA_W-1:0]   WDATA_S,
  input  logic [DATA_W/8-1:0] WSTRB_S,
  input  logic                WLAST_S,
  input  logic                WVALID_S,
  output logic                WREADY_S,
  output logic [ID_W-1:0]     BID_S,
  output logic [1:0]          BRESP_S,
  output logic                BVALID_S,
  input  logic                BREADY_S,
  output logic                CS,
  output logic                OE,
  output logic [DATA_W/8-1:0] WEB,
  output logic [MEM_AW-1:0]   A,
  output logic [DATA_W-1:0]   DI,
  input  logic [DATA_W-1:0]   DO
);

  state_e            state;
  logic [ID_W-1:0]   id_q;
  logic [MEM_AW-1:0] cur_addr;
  logic [MEM_AW-1:0] nxt_addr;
  logic              last;
  logic              ar_hs, aw_hs, r_hs, w_hs;

  // Size/burst fields and out-of-bank address bits carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{ARSIZE_S, ARBURST_S, AWSIZE_S, AWBURST_S,
                       ARADDR_S[ADDR_W-1:MEM_AW+2], ARADDR_S[1:0],
                       AWADDR_S[ADDR_W-1:MEM_AW+2], AWADDR_S[1:0]};

  // Readies are gated by reset so every AXI output reads 0 while held in reset.
  // AR takes priority: AW is refused in any cycle that also offers an AR.
  assign ARREADY_S = rst & (state == IDLE);
  assign AWREADY_S = rst & (state == IDLE) & ~ARVALID_S;
  assign WREADY_S  = (state == W_DATA);
  assign RVALID_S  = (state == R_DATA);
  assign BVALID_S  = (state == W_RESP);

  assign ar_hs = ARVALID_S & ARREADY_S;
  assign aw_hs = AWVALID_S & AWREADY_S;
  assign r_hs  = RVALID_S & RREADY_S;
  assign w_hs  = WVALID_S & WREADY_S;

  assign RID_S   = id_q;
  assign BID_S   = id_q;
  assign RDATA_S = RVALID_S ? DO : '0;
  assign RLAST_S = RVALID_S & last;
  assign RRESP_S = OKAY;
  assign BRESP_S = OKAY;

  sram_axi_slave_burst_counter #(
    .AW   (MEM_AW),
    .LEN_W(LEN_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (ar_hs | aw_hs),
    .inc      (r_hs | w_hs),
    .base     (ar_hs ? ARADDR_S[MEM_AW+1:2] : AWADDR_S[MEM_AW+1:2]),
    .len      (ar_hs ? ARLEN_S : AWLEN_S),
    .addr     (cur_addr),
    .next_addr(nxt_addr),
    .last     (last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      id_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ar_hs) begin
            id_q  <= ARID_S;
            state <= R_DATA;
          end else if (aw_hs) begin
            id_q  <= AWID_S;
            state <= W_DATA;
          end
        end
        R_DATA: if (r_hs && last) state <= IDLE;
        W_DATA: if (w_hs && WLAST_S) state <= W_RESP;
        W_RESP: if (BREADY_S) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // SRAM pins are steered combinationally so a read beat can present the
  // following address in the same cycle it is accepted (no bubbles), and a
  // write beat lands in the SRAM in its own handshake cycle.
  always_comb begin
    CS  = 1'b0;
    OE  = 1'b0;
    WEB = '1;
    A   = '0;
    DI  = '0;
    case (state)
      IDLE: begin
        if (ar_hs) begin
          CS = 1'b1;
          OE = 1'b1;
          A  = ARADDR_S[MEM_AW+1:2];
        end
      end
      R_DATA: begin
        // While stalled the current address is held so DO stays put.
        CS = ~(r_hs & last);
        OE = ~(r_hs & last);
        A  = RREADY_S ? nxt_addr : cur_addr;
      end
      W_DATA: begin
        if (w_hs) begin
          CS  = 1'b1;
          WEB = ~WSTRB_S;
          A   = cur_addr;
          DI  = WDATA_S;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sram_axi_slave.sv
module tb_sram_axi_slave;
  localparam int DEPTH = 1 << 14;
  localparam int MASK  = DEPTH - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  ARID_S, RID_S, AWID_S, BID_S;
  logic [31:0] ARADDR_S, AWADDR_S, RDATA_S, WDATA_S, DI, DO;
  logic [3:0]  ARLEN_S, AWLEN_S, WSTRB_S, WEB;
  logic [2:0]  ARSIZE_S, AWSIZE_S;
  logic [1:0]  ARBURST_S, AWBURST_S, RRESP_S, BRESP_S;
  logic        ARVALID_S, ARREADY_S, RLAST_S, RVALID_S, RREADY_S;
  logic        AWVALID_S, AWREADY_S, WLAST_S, WVALID_S, WREADY_S;
  logic        BVALID_S, BREADY_S, CS, OE;
  logic [13:0] A;

  sram_axi_slave dut (
    .clk(clk), .rst(rst),
    .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
    .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
    .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S),
    .RVALID_S(RVALID_S), .RREADY_S(RREADY_S),
    .AWID_S(AWID_S), .AWADDR_S(AWADDR_S), .AWLEN_S(AWLEN_S), .AWSIZE_S(AWSIZE_S),
    .AWBURST_S(AWBURST_S), .AWVALID_S(AWVALID_S), .AWREADY_S(AWREADY_S),
    .WDATA_S(WDATA_S), .WSTRB_S(WSTRB_S), .WLAST_S(WLAST_S), .WVALID_S(WVALID_S),
    .WREADY_S(WREADY_S), .BID_S(BID_S), .BRESP_S(BRESP_S), .BVALID_S(BVALID_S),
    .BREADY_S(BREADY_S), .CS(CS), .OE(OE), .WEB(WEB), .A(A), .DI(DI), .DO(DO)
  );

  // Physical SRAM macro model (what the DUT drives) and an independent
  // reference image of what memory should contain after each transaction.
  logic [31:0] sram    [0:DEPTH-1];
  logic [31:0] ref_mem [0:DEPTH-1];

  always @(posedge clk) begin
    if (CS) begin
      if (OE) DO <= sram[A];
      for (int b = 0; b < 4; b++)
        if (!WEB[b]) sram[A][b*8 +: 8] <= DI[b*8 +: 8];
    end
  end

  int checks = 0;
  int errors = 0;

  logic [31:0] rd_beats[$];
  int rd_bad_last, rd_bad_id, rd_unstable, rd_late, tmo;
  logic [31:0] wr_data[$];
  logic [3:0]  wr_strb[$];
  logic [3:0]  wr_web_first;
  logic [7:0]  wr_bid;
  int          wr_b_drop;

  task automatic axi_read(input logic [7:0] id, input logic [31:0] addr, input int len, input int mode);
    int n, beat, cyc;
    logic held_vld;
    logic [31:0] held;
    rd_beats.delete();
    rd_bad_last = 0; rd_bad_id = 0; rd_unstable = 0; rd_late = 0;
    @(posedge clk); #1;
    ARVALID_S = 1'b1; ARID_S = id; ARADDR_S = addr; ARLEN_S = 4'(len);
    #1;
    n = 0;
    while (!ARREADY_S && n < 50) begin @(posedge clk); #2; n++; end
    if (n >= 50) begin tmo++; ARVALID_S = 1'b0; return; end
    @(posedge clk); #1;
    ARVALID_S = 1'b0;
    beat = 0; cyc = 0; held_vld = 1'b0; held = '0;
    while (beat <= len && cyc < 200) begin
      case (mode)
        0:       RREADY_S = 1'b1;
        1:       RREADY_S = (cyc % 2 == 0);
        default: RREADY_S = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (cyc == 0 && !RVALID_S) rd_late++;
      if (RVALID_S) begin
        if (held_vld && RDATA_S !== held) rd_unstable++;
        if (RID_S !== id) rd_bad_id++;
        if (RLAST_S !== (beat == len)) rd_bad_last++;
        if (RREADY_S) begin
          rd_beats.push_back(RDATA_S);
          beat++;
          held_vld = 1'b0;
        end else begin
          held_vld = 1'b1;
          held = RDATA_S;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    RREADY_S = 1'b0;
    if (beat <= len) tmo++;
  endtask

  task automatic axi_write(input logic [7:0] id, input logic [31:0] addr, input int nbeats, input int bdelay);
    int n;
    wr_b_drop = 0; wr_web_first = 4'hx; wr_bid = 8'hxx;
    @(posedge clk); #1;
    AWVALID_S = 1'b1; AWID_S = id; AWADDR_S = addr; AWLEN_S = 4'(nbeats - 1);
    #1;
    n = 0;
    while (!AWREADY_S && n < 50) begin @(posedge clk); #2; n++; end
    if (n >= 50) begin tmo++; AWVALID_S = 1'b0; return; end
    @(posedge clk); #1;
    AWVALID_S = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      WVALID_S = 1'b1; WDATA_S = wr_data[i]; WSTRB_S = wr_strb[i];
      WLAST_S = (i == nbeats - 1);
      #1;
      n = 0;
      while (!WREADY_S && n < 50) begin @(posedge clk); #2; n++; end
      if (n >= 50) begin tmo++; WVALID_S = 1'b0; return; end
      if (i == 0) wr_web_first = WEB;
      @(posedge clk); #1;
    end
    WVALID_S = 1'b0; WLAST_S = 1'b0;
    BREADY_S = 1'b0;
    for (int d = 0; d < bdelay; d++) begin
      #1;
      if (!BVALID_S) wr_b_drop++;
      @(posedge clk); #1;
    end
    BREADY_S = 1'b1;
    #1;
    n = 0;
    while (!BVALID_S && n < 50) begin @(posedge clk); #2; n++; end
    if (n >= 50) tmo++;
    wr_bid = BID_S;
    @(posedge clk); #1;
    BREADY_S = 1'b0;
  endtask

  // Expected memory contents after a write: byte-merge under the strobes.
  task automatic ref_write(input int base, input int nbeats);
    for (int i = 0; i < nbeats; i++) begin
      int w;
      w = (base + i) & MASK;
      for (int b = 0; b < 4; b++)
        if (wr_strb[i][b]) ref_mem[w][b*8 +: 8] = wr_data[i][b*8 +: 8];
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if ({ARREADY_S, AWREADY_S, WREADY_S, RVALID_S, BVALID_S, RLAST_S, CS, OE} !== 8'h00) begin
      errors++;
      $display("FAIL reset_flags got %b exp 00000000",
               {ARREADY_S, AWREADY_S, WREADY_S, RVALID_S, BVALID_S, RLAST_S, CS, OE});
    end
    checks++;
    if (WEB !== 4'hF || A !== 14'd0) begin
      errors++; $display("FAIL reset_sram got WEB=%b A=%h exp WEB=1111 A=0", WEB, A);
    end
    checks++;
    if ({RRESP_S, BRESP_S} !== 4'd0 || RDATA_S !== 32'd0 || RID_S !== 8'd0 || BID_S !== 8'd0) begin
      errors++; $display("FAIL reset_data got RRESP=%h BRESP=%h RDATA=%h RID=%h BID=%h exp 0",
                         RRESP_S, BRESP_S, RDATA_S, RID_S, BID_S);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if (ARREADY_S !== 1'b1 || AWREADY_S !== 1'b1) begin
      errors++; $display("FAIL idle_ready got AR=%b AW=%b exp 1 1", ARREADY_S, AWREADY_S);
    end
  endtask

  task automatic test_single_read();
    sram[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
    axi_read(8'h15, 32'h10, 0, 0);
    checks++;
    if (rd_beats.size() != 1 || rd_beats[0] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL single_read got n=%0d d=%h exp n=1 d=deadbeef",
                         rd_beats.size(), rd_beats.size() > 0 ? rd_beats[0] : 32'hx);
    end
    checks++;
    if (rd_late != 0 || rd_bad_last != 0 || rd_bad_id != 0 || tmo != 0) begin
      errors++; $display("FAIL single_read_ctl got late=%0d last=%0d id=%0d tmo=%0d exp 0",
                         rd_late, rd_bad_last, rd_bad_id, tmo);
    end
  endtask

  task automatic test_burst_stall();
    axi_read(8'h42, 32'h0, 3, 1);
    checks++;
    if (rd_beats.size() != 4) begin
      errors++; $display("FAIL stall_count got %0d exp 4", rd_beats.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (rd_beats[i] !== ref_mem[i]) begin
          errors++; $display("FAIL stall_beat%0d got %h exp %h", i, rd_beats[i], ref_mem[i]);
        end
      end
    end
    checks++;
    if (rd_unstable != 0 || rd_bad_last != 0 || rd_late != 0 || tmo != 0) begin
      errors++; $display("FAIL stall_ctl got unstable=%0d last=%0d late=%0d tmo=%0d exp 0",
                         rd_unstable, rd_bad_last, rd_late, tmo);
    end
  endtask

  task automatic test_write_strobe();
    sram[2] = 32'h11223344; ref_mem[2] = 32'h11223344;
    wr_data = '{32'hAABBCCDD}; wr_strb = '{4'b0011};
    axi_write(8'h5A, 32'h8, 1, 3);
    ref_write(2, 1);
    checks++;
    if (wr_web_first !== 4'b1100) begin
      errors++; $display("FAIL strobe_web got %b exp 1100", wr_web_first);
    end
    checks++;
    if (wr_b_drop != 0 || wr_bid !== 8'h5A || tmo != 0) begin
      errors++; $display("FAIL strobe_b got drop=%0d bid=%h tmo=%0d exp 0 5a 0", wr_b_drop, wr_bid, tmo);
    end
    axi_read(8'h01, 32'h8, 0, 0);
    checks++;
    if (rd_beats.size() != 1 || rd_beats[0] !== 32'h1122CCDD) begin
      errors++; $display("FAIL strobe_readback got %h exp 1122ccdd",
                         rd_beats.size() > 0 ? rd_beats[0] : 32'hx);
    end
    // all-zero strobe must leave the word untouched
    wr_data = '{32'h99999999}; wr_strb = '{4'b0000};
    axi_write(8'h5B, 32'h8, 1, 0);
    ref_write(2, 1);
    axi_read(8'h02, 32'h8, 0, 0);
    checks++;
    if (rd_beats.size() != 1 || rd_beats[0] !== ref_mem[2]) begin
      errors++; $display("FAIL zero_strobe got %h exp %h",
                         rd_beats.size() > 0 ? rd_beats[0] : 32'hx, ref_mem[2]);
    end
  endtask

  task automatic test_conflict();
    logic [31:0] wd;
    wd = $urandom;
    @(posedge clk); #1;
    ARVALID_S = 1'b1; ARID_S = 8'h21; ARADDR_S = 32'h20; ARLEN_S = 4'd0;
    AWVALID_S = 1'b1; AWID_S = 8'h22; AWADDR_S = 32'h40; AWLEN_S = 4'd0;
    #1;
    checks++;
    if (ARREADY_S !== 1'b1 || AWREADY_S !== 1'b0) begin
      errors++; $display("FAIL conflict_ready got AR=%b AW=%b exp 1 0", ARREADY_S, AWREADY_S);
    end
    @(posedge clk); #1;
    ARVALID_S = 1'b0; RREADY_S = 1'b1;
    #1;
    checks++;
    if (RVALID_S !== 1'b1 || RDATA_S !== ref_mem[8] || AWREADY_S !== 1'b0 || RID_S !== 8'h21) begin
      errors++; $display("FAIL conflict_read got rv=%b d=%h aw=%b id=%h exp 1 %h 0 21",
                         RVALID_S, RDATA_S, AWREADY_S, RID_S, ref_mem[8]);
    end
    @(posedge clk); #1;
    RREADY_S = 1'b0;
    #1;
    checks++;
    if (AWREADY_S !== 1'b1) begin
      errors++; $display("FAIL conflict_aw_idle got %b exp 1", AWREADY_S);
    end
    @(posedge clk); #1;
    AWVALID_S = 1'b0;
    WVALID_S = 1'b1; WDATA_S = wd; WSTRB_S = 4'hF; WLAST_S = 1'b1;
    @(posedge clk); #1;
    WVALID_S = 1'b0; WLAST_S = 1'b0; BREADY_S = 1'b1;
    #1;
    checks++;
    if (BVALID_S !== 1'b1 || BID_S !== 8'h22 || BRESP_S !== 2'b00) begin
      errors++; $display("FAIL conflict_b got bv=%b id=%h resp=%h exp 1 22 0", BVALID_S, BID_S, BRESP_S);
    end
    @(posedge clk); #1;
    BREADY_S = 1'b0;
    ref_mem[16] = wd;
    axi_read(8'h23, 32'h40, 0, 0);
    checks++;
    if (rd_beats.size() != 1 || rd_beats[0] !== wd) begin
      errors++; $display("FAIL conflict_wdata got %h exp %h", rd_beats.size() > 0 ? rd_beats[0] : 32'hx, wd);
    end
  endtask

  task automatic test_wrap();
    axi_read(8'h77, 32'(MASK) << 2, 1, 0);
    checks++;
    if (rd_beats.size() != 2 || rd_beats[0] !== ref_mem[MASK] || rd_beats[1] !== ref_mem[0]) begin
      errors++; $display("FAIL wrap_read got n=%0d exp beats %h %h", rd_beats.size(), ref_mem[MASK], ref_mem[0]);
    end
    checks++;
    if (rd_bad_last != 0 || tmo != 0) begin
      errors++; $display("FAIL wrap_ctl got last=%0d tmo=%0d exp 0", rd_bad_last, tmo);
    end
  endtask

  task automatic test_reset_mid_burst();
    @(posedge clk); #1;
    ARVALID_S = 1'b1; ARID_S = 8'h33; ARADDR_S = 32'h0; ARLEN_S = 4'd3;
    @(posedge clk); #1;
    ARVALID_S = 1'b0; RREADY_S = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    checks++;
    if (RVALID_S !== 1'b0 || CS !== 1'b0 || OE !== 1'b0 || WEB !== 4'hF) begin
      errors++; $display("FAIL midreset_assert got rv=%b cs=%b oe=%b web=%b exp 0 0 0 1111",
                         RVALID_S, CS, OE, WEB);
    end
    @(posedge clk); #1;
    rst = 1'b1; RREADY_S = 1'b0;
    #1;
    checks++;
    if (RVALID_S !== 1'b0 || CS !== 1'b0 || ARREADY_S !== 1'b1) begin
      errors++; $display("FAIL midreset_after got rv=%b cs=%b ar=%b exp 0 0 1", RVALID_S, CS, ARREADY_S);
    end
    axi_read(8'h34, 32'h4, 2, 0);
    checks++;
    if (rd_beats.size() != 3 || rd_beats[0] !== ref_mem[1] || rd_beats[2] !== ref_mem[3] || tmo != 0) begin
      errors++; $display("FAIL midreset_newread got n=%0d tmo=%0d exp n=3 first=%h", rd_beats.size(), tmo, ref_mem[1]);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      int base, n;
      logic [7:0] id;
      logic [31:0] addr;
      id   = 8'($urandom);
      base = ($urandom_range(0, 3) == 0) ? (MASK - $urandom_range(0, 3)) : $urandom_range(0, 63);
      addr = ($urandom & 32'hFFFF_0003) | (32'(base) << 2);
      if ($urandom_range(0, 1) == 1) begin
        n = $urandom_range(1, 8);
        wr_data.delete(); wr_strb.delete();
        for (int i = 0; i < n; i++) begin
          wr_data.push_back($urandom);
          wr_strb.push_back(4'($urandom));
        end
        axi_write(id, addr, n, $urandom_range(0, 3));
        ref_write(base, n);
        checks++;
        if (tmo != 0 || wr_b_drop != 0 || wr_bid !== id || wr_web_first !== ~wr_strb[0]) begin
          errors++; $display("FAIL rand_write%0d got tmo=%0d drop=%0d bid=%h web=%b exp 0 0 %h %b",
                             t, tmo, wr_b_drop, wr_bid, wr_web_first, id, ~wr_strb[0]);
        end
      end else begin
        n = $urandom_range(0, 7);
        axi_read(id, addr, n, 2);
        checks++;
        if (rd_beats.size() != n + 1 || tmo != 0 || rd_bad_last != 0 || rd_bad_id != 0 ||
            rd_unstable != 0 || rd_late != 0) begin
          errors++; $display("FAIL rand_read%0d_ctl got n=%0d tmo=%0d last=%0d id=%0d unst=%0d late=%0d exp n=%0d",
                             t, rd_beats.size(), tmo, rd_bad_last, rd_bad_id, rd_unstable, rd_late, n + 1);
        end else begin
          for (int i = 0; i <= n; i++) begin
            checks++;
            if (rd_beats[i] !== ref_mem[(base + i) & MASK]) begin
              errors++; $display("FAIL rand_read%0d_beat%0d got %h exp %h",
                                 t, i, rd_beats[i], ref_mem[(base + i) & MASK]);
            end
          end
        end
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; tmo = 0; DO = '0;
    ARID_S = '0; ARADDR_S = '0; ARLEN_S = '0; ARSIZE_S = 3'b010; ARBURST_S = 2'b01; ARVALID_S = 1'b0;
    RREADY_S = 1'b0;
    AWID_S = '0; AWADDR_S = '0; AWLEN_S = '0; AWSIZE_S = 3'b010; AWBURST_S = 2'b01; AWVALID_S = 1'b0;
    WDATA_S = '0; WSTRB_S = '0; WLAST_S = 1'b0; WVALID_S = 1'b0; BREADY_S = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      sram[i] = $urandom;
      ref_mem[i] = sram[i];
    end
    test_reset();
    test_single_read();
    test_burst_stall();
    test_write_strobe();
    test_conflict();
    test_wrap();
    test_reset_mid_burst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
